// File: rtl/com_spi_pkg.sv
// com_spi_pkg: shared width, default timing and state type for the Pico-link SPI blocks
package com_spi_pkg;
   localparam int COM_DATA_W      = 16;
   localparam int COM_HALF_PERIOD = 6;
   localparam int COM_SETUP_CYC   = 2;
   localparam int COM_HOLD_CYC    = 2;
   localparam int COM_GAP_CYC     = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_HOLD,
      ST_GAP
   } com_tx_state_t;

   function automatic int com_max4(input int a, input int b, input int c, input int d);
      int m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return (d > m) ? d : m;
   endfunction
endpackage

// File: rtl/com_spi_tx_if.sv
// com_spi_tx_if: producer handshake plus SPI pins and status of the Pico-link transmitter
interface com_spi_tx_if import com_spi_pkg::*; #(
   parameter int DATA_W = COM_DATA_W
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              com_sclk_out;
   logic              com_mosi_out;
   logic              com_active_out;
   logic              busy;
   logic              frame_done;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, com_sclk_out, com_mosi_out, com_active_out, busy, frame_done
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, com_sclk_out, com_mosi_out, com_active_out, busy, frame_done
   );
endinterface

// File: rtl/com_tx_holdbuf.sv
// com_tx_holdbuf: one-entry pending word register between the producer and the shifter
module com_tx_holdbuf import com_spi_pkg::*; #(
   parameter int DATA_W = COM_DATA_W
) (
   input  logic              clk_25mhz,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full
);
   logic              r_full;
   logic              r_ready;
   logic [DATA_W-1:0] r_data;
   logic              w_load;
   logic              w_full_nxt;

   assign w_load     = i_valid && r_ready;
   assign w_full_nxt = w_load ? 1'b1 : (i_pop ? 1'b0 : r_full);
   assign o_ready    = r_ready;
   assign o_data     = r_data;
   assign o_full     = r_full;

   // Capture an offered word while empty; ready is registered and held low in reset
   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         r_full  <= 1'b0;
         r_ready <= 1'b0;
         r_data  <= '0;
      end else begin
         r_full  <= w_full_nxt;
         r_ready <= !w_full_nxt;
         if (w_load) r_data <= i_data;
      end
   end
endmodule

// File: rtl/com_spi_tx.sv
// com_spi_tx: MSB-first SPI initiator framing 16-bit words for the Pico link
module com_spi_tx import com_spi_pkg::*; #(
   parameter int DATA_W      = COM_DATA_W,
   parameter int HALF_PERIOD = COM_HALF_PERIOD,
   parameter int SETUP_CYC   = COM_SETUP_CYC,
   parameter int HOLD_CYC    = COM_HOLD_CYC,
   parameter int GAP_CYC     = COM_GAP_CYC
) (
   input  logic         clk_25mhz,
   input  logic         reset,
   com_spi_tx_if.slave  bus
);
   localparam int CNT_MAX = com_max4(HALF_PERIOD, SETUP_CYC, HOLD_CYC, GAP_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   com_tx_state_t     r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_len_m1;
   logic [BIT_W-1:0]  r_bit, w_bit_nxt;
   logic [DATA_W-1:0] r_sh, w_sh_nxt, w_pend;
   logic              w_full, w_pop, w_end, w_cs_nxt;
   logic              r_sclk, r_mosi, r_cs, r_busy, r_done;

   com_tx_holdbuf #(.DATA_W(DATA_W)) u_holdbuf (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .i_data    (bus.tx_data),
      .i_valid   (bus.tx_valid),
      .o_ready   (bus.tx_ready),
      .i_pop     (w_pop),
      .o_data    (w_pend),
      .o_full    (w_full)
   );

   assign w_len_m1 = (r_state == ST_SETUP) ? CNT_W'(SETUP_CYC - 1) :
                     (r_state == ST_HOLD)  ? CNT_W'(HOLD_CYC - 1)  :
                     (r_state == ST_GAP)   ? CNT_W'(GAP_CYC - 1)   : CNT_W'(HALF_PERIOD - 1);
   assign w_end    = r_cnt == w_len_m1;
   assign w_pop    = w_full && (r_state == ST_IDLE || (r_state == ST_GAP && w_end));
   assign w_cs_nxt = w_state_nxt inside {ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_HOLD};

   assign bus.com_sclk_out   = r_sclk;
   assign bus.com_mosi_out   = r_mosi;
   assign bus.com_active_out = r_cs;
   assign bus.busy           = r_busy;
   assign bus.frame_done     = r_done;

   // Phase sequencing: each timed state ends when the shared counter hits its length
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (w_end || r_state == ST_IDLE) ? '0 : r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_sh_nxt    = r_sh;
      case (r_state)
         ST_IDLE:     w_state_nxt = w_full ? ST_SETUP : ST_IDLE;
         ST_SETUP:    if (w_end) w_state_nxt = ST_SHIFT_LO;
         ST_SHIFT_LO: if (w_end) w_state_nxt = ST_SHIFT_HI;
         ST_SHIFT_HI: if (w_end) begin
            if (r_bit == BIT_W'(DATA_W - 1)) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_SHIFT_LO;
               w_sh_nxt    = {r_sh[DATA_W-2:0], 1'b0};
               w_bit_nxt   = r_bit + 1'b1;
            end
         end
         ST_HOLD:     if (w_end) w_state_nxt = ST_GAP;
         ST_GAP:      if (w_end) w_state_nxt = w_full ? ST_SETUP : ST_IDLE;
         default:     w_state_nxt = ST_IDLE;
      endcase
      if (w_pop) begin
         w_sh_nxt  = w_pend;
         w_bit_nxt = '0;
      end
   end

   // State/counters and pins, all registered from the next-state decode
   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_sh    <= w_sh_nxt;
         r_sclk  <= w_state_nxt == ST_SHIFT_HI;
         r_mosi  <= w_cs_nxt && w_sh_nxt[DATA_W-1];
         r_cs    <= w_cs_nxt;
         r_busy  <= w_state_nxt != ST_IDLE;
         r_done  <= r_state == ST_HOLD && w_state_nxt == ST_GAP;
      end
   end
endmodule

// File: tb/tb_com_spi_tx.sv
// tb_com_spi_tx: directed checks of the SPI initiator at default and minimum timing
module tb_com_spi_tx;
   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0][15:0] tx_data;
   logic [1:0]       tx_valid;
   logic [1:0]       ready, cs, sclk, mosi, busy, done;
   int               n_checks = 0;
   int               n_errors = 0;

   logic [15:0] q_word[2][$];
   int          q_len[2][$];
   int          q_bits[2][$];
   int          q_gap[2][$];
   int          cs_len[2], nbits[2], gap_cnt[2], done_cnt[2], edge_err[2], done_bad[2];
   logic [15:0] sh[2];
   logic        prev_cs[2], prev_sclk[2], gap_valid[2];

   always #20 clk = ~clk;

   com_spi_tx_if #(.DATA_W(16)) if_a ();
   com_spi_tx_if #(.DATA_W(16)) if_b ();

   com_spi_tx u_dut_a (.clk_25mhz(clk), .reset(reset_n), .bus(if_a));
   com_spi_tx #(.HALF_PERIOD(1), .SETUP_CYC(1), .HOLD_CYC(1), .GAP_CYC(1))
      u_dut_b (.clk_25mhz(clk), .reset(reset_n), .bus(if_b));

   assign if_a.tx_data = tx_data[0];
   assign if_a.tx_valid = tx_valid[0];
   assign if_b.tx_data = tx_data[1];
   assign if_b.tx_valid = tx_valid[1];
   assign ready = {if_b.tx_ready, if_a.tx_ready};
   assign cs = {if_b.com_active_out, if_a.com_active_out};
   assign sclk = {if_b.com_sclk_out, if_a.com_sclk_out};
   assign mosi = {if_b.com_mosi_out, if_a.com_mosi_out};
   assign busy = {if_b.busy, if_a.busy};
   assign done = {if_b.frame_done, if_a.frame_done};

   // Frame decoder acting as the receiving end: samples MOSI on each SCLK rise inside CS
   for (genvar g = 0; g < 2; g++) begin : g_mon
      always @(negedge clk) begin
         if (!reset_n) begin
            prev_cs[g] <= 1'b0;
            prev_sclk[g] <= 1'b0;
            gap_valid[g] <= 1'b0;
         end else begin
            if (sclk[g] && !prev_sclk[g]) begin
               if (cs[g]) begin
                  sh[g] <= {sh[g][14:0], mosi[g]};
                  nbits[g] <= nbits[g] + 1;
               end else edge_err[g] <= edge_err[g] + 1;
            end
            if (cs[g] && !prev_cs[g]) begin
               cs_len[g] <= 1;
               nbits[g] <= 0;
               sh[g] <= 16'h0;
               if (gap_valid[g]) q_gap[g].push_back(gap_cnt[g]);
            end else if (cs[g]) cs_len[g] <= cs_len[g] + 1;
            if (!cs[g] && prev_cs[g]) begin
               q_word[g].push_back(sh[g]);
               q_len[g].push_back(cs_len[g]);
               q_bits[g].push_back(nbits[g]);
               gap_cnt[g] <= 1;
               gap_valid[g] <= 1'b1;
            end else if (!cs[g]) gap_cnt[g] <= gap_cnt[g] + 1;
            if (done[g] != (!cs[g] && prev_cs[g])) done_bad[g] <= done_bad[g] + 1;
            if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
            prev_cs[g] <= cs[g];
            prev_sclk[g] <= sclk[g];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int d, input logic [15:0] w);
      int n = 0;
      tx_data[d] = w;
      tx_valid[d] = 1'b1;
      while (!ready[d] && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("accept_tmo", 32'(n < 600), 1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_words(input int d, input int k);
      int n = 0;
      while (q_word[d].size() < k && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("frame_tmo", q_word[d].size(), k);
   endtask

   task automatic clear_q(input int d);
      q_word[d].delete();
      q_len[d].delete();
      q_bits[d].delete();
      q_gap[d].delete();
   endtask

   initial begin
      int n;
      int snap;
      tx_valid = '0;
      tx_data = '0;
      repeat (3) @(negedge clk);
      check("rst_cs", cs, 0);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", ready, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_rel", ready, 2'b11);

      push(0, 16'hC0DE);
      tx_valid[0] = 1'b0;
      check("cs_early", cs[0], 0);
      @(negedge clk);
      check("cs_rise", cs[0], 1);
      check("mosi_msb", mosi[0], 1);
      n = 0;
      while (!done[0] && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done[0], 1);
      check("cs_fall", cs[0], 0);
      check("busy_gap0", busy[0], 1);
      @(negedge clk);
      check("done_pulse", done[0], 0);
      check("busy_gap1", busy[0], 1);
      @(negedge clk);
      check("busy_idle", busy[0], 0);
      wait_words(0, 1);
      check("t1_word", q_word[0][0], 16'hC0DE);
      check("t1_len", q_len[0][0], 196);
      check("t1_bits", q_bits[0][0], 16);

      clear_q(0);
      push(0, 16'hC0DE);
      push(0, 16'h1234);
      tx_valid[0] = 1'b0;
      wait_words(0, 2);
      check("t2_w0", q_word[0][0], 16'hC0DE);
      check("t2_w1", q_word[0][1], 16'h1234);
      check("t2_gap", q_gap[0][q_gap[0].size() - 1], 2);
      check("t2_len1", q_len[0][1], 196);

      clear_q(0);
      push(0, 16'hA5F0);
      push(0, 16'h0000);
      check("ready_full", ready[0], 0);
      push(0, 16'hFFFF);
      tx_valid[0] = 1'b0;
      wait_words(0, 3);
      check("t3_w0", q_word[0][0], 16'hA5F0);
      check("t3_w1", q_word[0][1], 16'h0000);
      check("t3_w2", q_word[0][2], 16'hFFFF);
      check("t3_gap1", q_gap[0][1], 2);
      check("t3_gap2", q_gap[0][2], 2);
      check("t3_bits2", q_bits[0][2], 16);

      clear_q(0);
      snap = done_cnt[0];
      push(0, 16'hFFFF);
      tx_valid[0] = 1'b0;
      n = 0;
      while (!cs[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("t4_cs", cs[0], 1);
      repeat (88) @(negedge clk);
      check("t4_mosi_b7", mosi[0], 1);
      reset_n = 1'b0;
      @(negedge clk);
      check("t4_cs0", cs[0], 0);
      check("t4_sclk0", sclk[0], 0);
      check("t4_mosi0", mosi[0], 0);
      check("t4_busy0", busy[0], 0);
      check("t4_done0", done[0], 0);
      check("t4_ready0", ready[0], 0);
      repeat (4) @(negedge clk);
      check("t4_no_done", done_cnt[0], snap);
      check("t4_no_word", q_word[0].size(), 0);
      reset_n = 1'b1;
      @(negedge clk);
      push(0, 16'h0001);
      tx_valid[0] = 1'b0;
      wait_words(0, 1);
      check("t4_word", q_word[0][0], 16'h0001);
      check("t4_len", q_len[0][0], 196);

      clear_q(1);
      push(1, 16'h8001);
      push(1, 16'h7FFE);
      tx_valid[1] = 1'b0;
      wait_words(1, 2);
      check("sw_w0", q_word[1][0], 16'h8001);
      check("sw_w1", q_word[1][1], 16'h7FFE);
      check("sw_len", q_len[1][0], 34);
      check("sw_bits", q_bits[1][1], 16);
      check("sw_gap", q_gap[1][0], 1);

      repeat (4) @(negedge clk);
      check("edge_a", edge_err[0], 0);
      check("edge_b", edge_err[1], 0);
      check("done_a_ok", done_bad[0], 0);
      check("done_b_ok", done_bad[1], 0);
      check("done_a_cnt", done_cnt[0], 7);
      check("done_b_cnt", done_cnt[1], 2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
